// File: rtl/debug_controller.sv
// MCU-side command executor for the UART debugger: pause/resume, memory and
// register-file access, and a small PC breakpoint unit.
module debug_controller #(
  parameter int NUM_BP  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  input  logic        out_valid,
  output logic        ctrlr_busy,
  output logic [31:0] d_rd,
  output logic        error,
  input  logic [31:0] mcu_pc,
  output logic        mcu_pause,
  input  logic        mcu_paused,
  output logic        mcu_reset,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_dout,
  input  logic        mem_ack,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wd,
  output logic        rf_we,
  input  logic [31:0] rf_rd
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [3:0] CMD_PAUSE  = 4'h1;
  localparam logic [3:0] CMD_RESUME = 4'h2;
  localparam logic [3:0] CMD_MRST   = 4'h3;
  localparam logic [3:0] CMD_STATUS = 4'h4;
  localparam logic [3:0] CMD_MEM_RD = 4'h5;
  localparam logic [3:0] CMD_MEM_WR = 4'h6;
  localparam logic [3:0] CMD_REG_RD = 4'h7;
  localparam logic [3:0] CMD_REG_WR = 4'h8;
  localparam logic [3:0] CMD_BP_SET = 4'h9;
  localparam logic [3:0] CMD_BP_CLR = 4'hA;
  localparam logic [3:0] CMD_PC_RD  = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT_PAUSE, S_MEM_ACCESS, S_REG_ACCESS, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [3:0]    r_cmd;
  logic [31:0]   r_addr, r_din, r_result, r_d_rd;
  logic          r_busy, r_error, r_err_pend, r_bp_sticky;
  logic          r_mcu_pause, r_mcu_reset, r_mem_we, r_mem_re, r_rf_we;
  logic [31:0]   r_mem_addr, r_mem_din, r_rf_wd;
  logic [4:0]    r_rf_addr;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_bp_val [NUM_BP];
  logic [NUM_BP-1:0] r_bp_valid;
  logic          w_cmd_ok, w_tmo, w_match, w_hit;

  assign ctrlr_busy = r_busy;
  assign d_rd       = r_d_rd;
  assign error      = r_error;
  assign mcu_pause  = r_mcu_pause;
  assign mcu_reset  = r_mcu_reset;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
  assign mem_we     = r_mem_we;
  assign mem_re     = r_mem_re;
  assign rf_addr    = r_rf_addr;
  assign rf_wd      = r_rf_wd;
  assign rf_we      = r_rf_we;

  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));
  assign w_hit = w_match & ~r_mcu_pause;

  // Legality of the latched command: memory/register access needs a halted MCU
  always_comb begin
    w_cmd_ok = 1'b0;
    case (r_cmd)
      CMD_PAUSE, CMD_RESUME, CMD_MRST, CMD_STATUS, CMD_PC_RD: w_cmd_ok = 1'b1;
      CMD_MEM_RD, CMD_MEM_WR, CMD_REG_RD, CMD_REG_WR:        w_cmd_ok = mcu_paused;
      CMD_BP_SET, CMD_BP_CLR: w_cmd_ok = ({1'b0, r_addr[2:0]} < 4'(NUM_BP));
      default:                w_cmd_ok = 1'b0;
    endcase
  end

  // Breakpoint comparators, evaluated every cycle
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      w_match = w_match | (r_bp_valid[i] & (r_bp_val[i] == mcu_pc));
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (out_valid) w_next = S_DECODE;
        else           w_next = S_IDLE;
      end
      S_DECODE: begin
        if (!w_cmd_ok)                                       w_next = S_DONE;
        else if (r_cmd == CMD_PAUSE)                         w_next = S_WAIT_PAUSE;
        else if ((r_cmd == CMD_MEM_RD) || (r_cmd == CMD_MEM_WR)) w_next = S_MEM_ACCESS;
        else if (r_cmd == CMD_REG_RD)                        w_next = S_REG_ACCESS;
        else                                                 w_next = S_DONE;
      end
      S_WAIT_PAUSE: begin
        if (mcu_paused || w_tmo) w_next = S_DONE;
        else                     w_next = S_WAIT_PAUSE;
      end
      S_MEM_ACCESS: begin
        if (mem_ack || w_tmo) w_next = S_DONE;
        else                  w_next = S_MEM_ACCESS;
      end
      S_REG_ACCESS: w_next = S_DONE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Datapath, MCU-facing strobes and breakpoint storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd <= 4'h0;  r_addr <= 32'h0;  r_din <= 32'h0;
      r_result <= 32'h0;  r_d_rd <= 32'h0;  r_busy <= 1'b0;
      r_error <= 1'b0;  r_err_pend <= 1'b0;  r_bp_sticky <= 1'b0;
      r_mcu_pause <= 1'b0;  r_mcu_reset <= 1'b0;
      r_mem_we <= 1'b0;  r_mem_re <= 1'b0;  r_rf_we <= 1'b0;
      r_mem_addr <= 32'h0;  r_mem_din <= 32'h0;  r_rf_wd <= 32'h0;
      r_rf_addr <= 5'h0;  r_cnt <= '0;  r_bp_valid <= '0;
      for (int i = 0; i < NUM_BP; i++) r_bp_val[i] <= 32'h0;
    end else begin
      r_mcu_reset <= 1'b0;
      r_rf_we     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (out_valid) begin
            r_cmd <= cmd;  r_addr <= addr;  r_din <= d_in;
            r_busy <= 1'b1;  r_error <= 1'b0;
          end
        end
        S_DECODE: begin
          r_cnt      <= '0;
          r_result   <= 32'h0;
          r_err_pend <= ~w_cmd_ok;
          if (w_cmd_ok) begin
            case (r_cmd)
              CMD_PAUSE:  r_mcu_pause <= 1'b1;
              CMD_RESUME: r_mcu_pause <= 1'b0;
              CMD_MRST:   r_mcu_reset <= 1'b1;
              CMD_STATUS: begin
                r_result    <= {30'h0, r_bp_sticky, mcu_paused};
                r_bp_sticky <= 1'b0;
              end
              CMD_MEM_RD: begin
                r_mem_addr <= r_addr;  r_mem_re <= 1'b1;
              end
              CMD_MEM_WR: begin
                r_mem_addr <= r_addr;  r_mem_din <= r_din;  r_mem_we <= 1'b1;
              end
              CMD_REG_RD: r_rf_addr <= r_addr[4:0];
              CMD_REG_WR: begin
                r_rf_addr <= r_addr[4:0];  r_rf_wd <= r_din;  r_rf_we <= 1'b1;
              end
              CMD_BP_SET, CMD_BP_CLR: begin
                for (int i = 0; i < NUM_BP; i++) begin
                  if (3'(i) == r_addr[2:0]) begin
                    r_bp_valid[i] <= (r_cmd == CMD_BP_SET);
                    if (r_cmd == CMD_BP_SET) r_bp_val[i] <= r_din;
                  end
                end
              end
              CMD_PC_RD: r_result <= mcu_pc;
              default:   r_result <= 32'h0;
            endcase
          end
        end
        S_WAIT_PAUSE: begin
          // a PAUSE timeout leaves the halt request asserted
          if (!mcu_paused) begin
            if (w_tmo) r_err_pend <= 1'b1;
            else       r_cnt <= r_cnt + CW'(1);
          end
        end
        S_MEM_ACCESS: begin
          if (mem_ack) begin
            r_mem_re <= 1'b0;  r_mem_we <= 1'b0;
            if (r_cmd == CMD_MEM_RD) r_result <= mem_dout;
          end else if (w_tmo) begin
            r_mem_re <= 1'b0;  r_mem_we <= 1'b0;  r_err_pend <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_REG_ACCESS: r_result <= rf_rd;
        S_DONE: begin
          r_busy  <= 1'b0;
          r_d_rd  <= r_err_pend ? 32'h0 : r_result;
          r_error <= r_err_pend;
        end
        default: r_busy <= 1'b0;
      endcase
      // a breakpoint hit overrides RESUME and a STATUS clear in the same cycle
      if (w_hit) begin
        r_mcu_pause <= 1'b1;
        r_bp_sticky <= 1'b1;
      end
    end
  end

endmodule
